seg7_capture: RTL and testbench

//   Receive-side counterpart of the chip's 7-segment display output: samples a 7-bit

---
 rtl/seg7_pkg.sv | 58 +++++
 rtl/seg7_capture_fifo.sv | 45 ++++
 rtl/seg7_capture.sv | 94 +++++++++
 tb/tb_seg7_capture.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph constants, event payload and decode for the 7-segment capture path.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned EVT_W = 6;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] digit;
    } seg_evt_t;

    // Exactly one of glyph / blank / err is reported; digit stays 0 unless a glyph matched.
    function automatic seg_evt_t seg_decode(input logic [SEG_W-1:0] seg);
        seg_evt_t evt;
        evt = '0;
        case (seg)
            SEG_0:     evt.digit = 4'h0;
            SEG_1:     evt.digit = 4'h1;
            SEG_2:     evt.digit = 4'h2;
            SEG_3:     evt.digit = 4'h3;
            SEG_4:     evt.digit = 4'h4;
            SEG_5:     evt.digit = 4'h5;
            SEG_6:     evt.digit = 4'h6;
            SEG_7:     evt.digit = 4'h7;
            SEG_8:     evt.digit = 4'h8;
            SEG_9:     evt.digit = 4'h9;
            SEG_A:     evt.digit = 4'hA;
            SEG_B:     evt.digit = 4'hB;
            SEG_C:     evt.digit = 4'hC;
            SEG_D:     evt.digit = 4'hD;
            SEG_E:     evt.digit = 4'hE;
            SEG_F:     evt.digit = 4'hF;
            SEG_BLANK: evt.blank = 1'b1;
            default:   evt.err   = 1'b1;
        endcase
        return evt;
    endfunction

endpackage

// File: rtl/seg7_capture_fifo.sv
// Generic synchronous FIFO; pointers carry an extra wrap bit so full and empty never alias.
module seg_event_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop_c;
    logic             do_push_c;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop_c  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push_c = push && (!full || do_pop_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/seg7_capture.sv
// Samples an asynchronous 7-segment bus, qualifies stable patterns and queues decoded digits.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [6:0] segments_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_blank,
    output logic       out_err,
    output logic       overflow,
    input  logic       clr_ovf
);
    localparam int unsigned       CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0] s1;
    logic [SEG_W-1:0] s2;
    logic [SEG_W-1:0] cand;
    logic [SEG_W-1:0] last;
    logic [CNT_W-1:0] cnt;
    logic             push_c;
    logic             pop_c;
    logic             drop_c;
    logic             fifo_full;
    logic             fifo_empty;
    seg_evt_t         evt_in_c;
    seg_evt_t         head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= segments_in;
            s2 <= s1;
        end
    end

    // last suppresses a repeat event when a glitch returns to the already-reported pattern.
    assign push_c = ena && (cnt == CNT_MAX) && (cand != last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= '0;
            cnt  <= '0;
            last <= '0;
        end else if (ena) begin
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (push_c) last <= cand;
        end
    end

    assign evt_in_c = seg_decode(cand);
    assign pop_c    = out_valid && out_ready;
    assign drop_c   = push_c && fifo_full && !pop_c;

    seg_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .din   (evt_in_c),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (drop_c)  overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    assign out_valid = !fifo_empty;
    assign out_digit = head.digit;
    assign out_blank = head.blank;
    assign out_err   = head.err;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed and randomized checks of seg7_capture against a run-length reference model.
module tb_seg7_capture;

    localparam int unsigned SC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [6:0] segments_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_blank;
    logic       out_err;
    logic       overflow;
    logic       clr_ovf;

    int checks = 0;
    int errors = 0;

    logic [5:0] got_q [$];
    logic [5:0] exp_q [$];

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_capture #(.STABLE_CYCLES(SC), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .segments_in (segments_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_digit   (out_digit),
        .out_blank   (out_blank),
        .out_err     (out_err),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    // Record every accepted event as {err, blank, digit}.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({out_err, out_blank, out_digit});
    end

    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        if (p == 7'h00) return 6'b01_0000;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == p) return {2'b00, 4'(i)};
        end
        return 6'b10_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] p, input int n);
        segments_in = p;
        repeat (n) step();
    endtask

    task automatic check_events(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_evt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [6:0] cur_pat;
        logic [6:0] last_model;
        logic [6:0] p;
        int         run_len;
        int         hold;

        rst_n = 1'b0; ena = 1'b1; segments_in = 7'h00; out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_digit", 32'(out_digit), 0);
        check("rst_ovf",   32'(overflow),  0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("idle_valid_%0d", k), 32'(out_valid), 0);
        end
        check("idle_ovf", 32'(overflow), 0);

        // First-event latency: valid appears after edge 7 and lasts one cycle.
        segments_in = 7'h5B; out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("lat_valid_e%0d", k), 32'(out_valid), (k == 7) ? 1 : 0);
            if (k == 7) begin
                check("lat_digit", 32'(out_digit), 2);
                check("lat_blank", 32'(out_blank), 0);
                check("lat_err",   32'(out_err),   0);
            end
        end
        got_q.delete();

        // Short glitch inside a stable pattern yields a single event.
        drive(7'h4F, 10); drive(7'h06, 2); drive(7'h4F, 15);
        exp_q.push_back(6'h03);
        check_events("glitch");

        // Overflow: five patterns into a four-entry queue with no consumer.
        out_ready = 1'b0;
        drive(7'h3F, 10); drive(7'h06, 10); drive(7'h5B, 10); drive(7'h4F, 10); drive(7'h66, 10);
        check("ovf_valid", 32'(out_valid), 1);
        check("ovf_flag",  32'(overflow),  1);
        check("ovf_head",  32'(out_digit), 0);
        out_ready = 1'b1;
        repeat (8) step();
        out_ready = 1'b0;
        for (int d = 0; d < 4; d++) exp_q.push_back(6'(d));
        check_events("drain");
        check("ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 0);

        // Error and blank decode.
        out_ready = 1'b1;
        drive(7'h55, 10); drive(7'h00, 10);
        exp_q.push_back(6'b10_0000);
        exp_q.push_back(6'b01_0000);
        check_events("err_blank");

        // Detector frozen while ena=0; resumes on fresh s2.
        ena = 1'b0;
        drive(7'h7F, 10);
        check("frozen_events", 32'(got_q.size()), 0);
        ena = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("resume_valid_e%0d", k), 32'(out_valid), (k == 5) ? 1 : 0);
            if (k == 5) check("resume_digit", 32'(out_digit), 8);
        end
        got_q.delete();

        // Reset mid-operation discards queue and detector state.
        out_ready = 1'b0;
        drive(7'h3F, 10); drive(7'h06, 10);
        check("pre_rst_valid", 32'(out_valid), 1);
        drive(7'h5B, 3);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_digit", 32'(out_digit), 0);
        repeat (3) step();
        rst_n = 1'b1; out_ready = 1'b1;
        got_q.delete();
        repeat (12) step();
        exp_q.push_back(6'h02);
        check_events("post_rst");

        // Randomized pattern runs; an event is due when a run reaches SC samples and
        // differs from the last reported pattern.
        cur_pat = 7'h5B; last_model = 7'h5B; run_len = 100;
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 9) < 5)      p = glyph[$urandom_range(0, 15)];
            else if ($urandom_range(0, 4) < 2) p = 7'h00;
            else                               p = 7'($urandom);
            hold = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 10));
            if (seg == 59) hold = 12;
            for (int c = 0; c < hold; c++) begin
                segments_in = p;
                if (p == cur_pat) run_len++;
                else begin
                    cur_pat = p;
                    run_len = 1;
                end
                if (run_len == SC && p != last_model) begin
                    exp_q.push_back(ref_decode(p));
                    last_model = p;
                end
                step();
            end
        end
        repeat (8) step();
        check("rand_ovf", 32'(overflow), 0);
        check_events("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
